// File: rtl/alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : alu_arbiter
// Description: Two-requester front end for one shared multi-cycle ALU.
//              Round-robin grant, one operation in flight, registered ALU
//              drive, SETTLE-cycle result capture, valid/ready response port.
//              Illegal opcodes are answered with rsp_err and never reach the ALU.
//              Optional macro ALU_ARBITER_CPSR_EN adds the cpsr status register;
//              without it cpsr is tied to zero.
// Revision   : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  // response
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_r,
  output logic [4:0]       rsp_flags,
  output logic             rsp_err,
  // shared ALU
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_div_invalid,
  // status
  output logic             busy,
  output logic [3:0]       cpsr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value loaded on a legal acceptance; SETTLE is limited to 1..7.
  localparam logic [2:0] LOAD = 3'(SETTLE - 1);

  state_t           state;
  logic [2:0]       cnt;
  logic             last_grant;
  logic             op_id;
  logic             grant;
  logic             accept;
  logic             sel_legal;
  logic             capture;
  logic [4:0]       sel_opcode;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;

  // Opcode map: 00000..10000, 11000..11100 and 11110 are implemented.
  function automatic logic is_legal(input logic [4:0] op);
    return (op <= 5'b10000) ||
           ((op >= 5'b11000) && (op <= 5'b11100)) ||
           (op == 5'b11110);
  endfunction

  // Grant: a lone valid requester wins; on contention alternate against last_grant.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready only for the granted requester, only in IDLE, never while reset is asserted.
  assign req0_ready = reset_n && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = reset_n && (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_opcode = grant ? req1_opcode : req0_opcode;
  assign sel_x      = grant ? req1_x      : req0_x;
  assign sel_y      = grant ? req1_y      : req0_y;
  assign sel_legal  = is_legal(sel_opcode);

  // The edge that samples the ALU outputs is the last WAIT cycle.
  assign capture    = (state == WAIT) && (cnt == 3'd0);
  assign busy       = (state != IDLE);

  // Control FSM with registered ALU drive and response outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      alu_opcode <= 5'd0;
      alu_x      <= '0;
      alu_y      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_r      <= '0;
      rsp_flags  <= 5'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            op_id      <= grant;
            if (sel_legal) begin
              alu_opcode <= sel_opcode;
              alu_x      <= sel_x;
              alu_y      <= sel_y;
              cnt        <= LOAD;
              state      <= WAIT;
            end else begin
              // Illegal opcode: answer immediately, ALU drive untouched.
              rsp_r     <= '0;
              rsp_flags <= 5'd0;
              rsp_err   <= 1'b1;
              rsp_id    <= grant;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        WAIT: begin
          if (capture) begin
            rsp_r     <= alu_r;
            rsp_flags <= {alu_div_invalid, alu_overflow, alu_negative,
                          alu_zero, alu_cout};
            rsp_err   <= 1'b0;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          // Response fields hold until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ARBITER_CPSR_EN
  logic [3:0] cpsr_q;

  // Status register follows the ALU flags at every legal capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpsr_q <= 4'b0000;
    end else if (capture) begin
      cpsr_q <= {alu_negative, alu_zero, alu_cout, alu_overflow};
    end
  end

  assign cpsr = cpsr_q;
`else
  assign cpsr = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module     : tb_alu_arbiter
// Description: Self-checking bench for alu_arbiter. The bench plays the shared
//              ALU, drives table vectors plus hand-written corner sequences,
//              and checks responses against a scoreboard queue.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int S1 = 1;
  localparam int S4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_x, req0_y, req1_x, req1_y;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_r, alu_x, alu_y, alu_r;
  logic [4:0]  rsp_flags, alu_opcode;
  logic        alu_overflow, alu_negative, alu_zero, alu_cout, alu_div_invalid;
  logic [3:0]  cpsr;
  logic [20:0] alu_out;

  logic        s4_req0_valid, s4_req1_valid, s4_req0_ready, s4_req1_ready;
  logic        s4_rsp_valid, s4_rsp_ready, s4_rsp_id, s4_rsp_err, s4_busy;
  logic [15:0] s4_rsp_r, s4_alu_x, s4_alu_y, s4_alu_r;
  logic [4:0]  s4_rsp_flags, s4_alu_opcode;
  logic        s4_alu_overflow, s4_alu_negative, s4_alu_zero, s4_alu_cout, s4_alu_div_invalid;
  logic [3:0]  s4_cpsr;
  logic [20:0] s4_alu_out;

  // Reference ALU: returns {r[15:0], div_invalid, overflow, negative, zero, cout}.
  function automatic logic [20:0] alu_fn(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] s;
    logic [15:0] r;
    logic ov, c, dv, n, z;
    r = 16'h0; ov = 1'b0; c = 1'b0; dv = 1'b0;
    case (op)
      5'b00001: begin
        s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16];
        ov = (x[15] == y[15]) && (r[15] != x[15]);
      end
      5'b00010, 5'b00101, 5'b11110: begin
        s = {1'b0, x} - {1'b0, y}; r = s[15:0]; c = (x >= y);
        ov = (x[15] != y[15]) && (r[15] != x[15]);
      end
      5'b01101: begin
        if (y == 16'h0) dv = 1'b1;
        else r = x / y;
      end
      default: r = x ^ y;
    endcase
    n = r[15];
    z = (r == 16'h0);
    if (op == 5'b00101 || op == 5'b11110) r = 16'h0;
    return {r, dv, ov, n, z, c};
  endfunction

  assign alu_out = alu_fn(alu_opcode, alu_x, alu_y);
  assign alu_r   = alu_out[20:5];
  assign {alu_div_invalid, alu_overflow, alu_negative, alu_zero, alu_cout} = alu_out[4:0];

  assign s4_alu_out = alu_fn(s4_alu_opcode, s4_alu_x, s4_alu_y);
  assign s4_alu_r   = s4_alu_out[20:5];
  assign {s4_alu_div_invalid, s4_alu_overflow, s4_alu_negative, s4_alu_zero, s4_alu_cout} = s4_alu_out[4:0];

  alu_arbiter #(.WIDTH(16), .SETTLE(S1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y), .alu_r(alu_r),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_div_invalid(alu_div_invalid), .busy(busy), .cpsr(cpsr)
  );

  alu_arbiter #(.WIDTH(16), .SETTLE(S4)) dut_s4 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(s4_req0_valid), .req0_ready(s4_req0_ready), .req0_opcode(req0_opcode), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(s4_req1_valid), .req1_ready(s4_req1_ready), .req1_opcode(req1_opcode), .req1_x(req1_x), .req1_y(req1_y),
    .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready), .rsp_id(s4_rsp_id), .rsp_r(s4_rsp_r), .rsp_flags(s4_rsp_flags), .rsp_err(s4_rsp_err),
    .alu_opcode(s4_alu_opcode), .alu_x(s4_alu_x), .alu_y(s4_alu_y), .alu_r(s4_alu_r),
    .alu_overflow(s4_alu_overflow), .alu_negative(s4_alu_negative), .alu_zero(s4_alu_zero), .alu_cout(s4_alu_cout),
    .alu_div_invalid(s4_alu_div_invalid), .busy(s4_busy), .cpsr(s4_cpsr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard entry: response fields plus ALU drive / cpsr expected at that time.
  typedef struct {
    logic        id;
    logic [15:0] r;
    logic [4:0]  flags;
    logic        err;
    logic [3:0]  cpsr;
    logic [4:0]  aop;
    logic [15:0] ax;
    logic [15:0] ay;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Running model of the last legal operation.
  logic [3:0]  m_cpsr;
  logic [4:0]  m_aop;
  logic [15:0] m_ax, m_ay;

  task automatic model_reset();
    m_cpsr = 4'h0; m_aop = 5'h0; m_ax = 16'h0; m_ay = 16'h0;
  endtask

  task automatic push(input logic id, input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] r, input logic [4:0] fl, input logic err);
    exp_t e;
    if (!err) begin
      m_aop = op; m_ax = x; m_ay = y;
      m_cpsr = {fl[2], fl[1], fl[0], fl[3]};
    end
    e.id = id; e.r = r; e.flags = fl; e.err = err;
`ifdef ALU_ARBITER_CPSR_EN
    e.cpsr = m_cpsr;
`else
    e.cpsr = 4'h0;
`endif
    e.aop = m_aop; e.ax = m_ax; e.ay = m_ay;
    e.acc_cyc = cyc;
    e.lat = err ? -1 : S1;
    sb.push_back(e);
  endtask

  // Response monitor for the SETTLE=1 instance.
  exp_t mon_e;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (rsp_valid && !prev_v && sb.size() != 0 && sb[0].lat >= 0)
        chk("rsp_latency", cyc - sb[0].acc_cyc, sb[0].lat);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", rsp_id, mon_e.id);
          chk("rsp_r", rsp_r, mon_e.r);
          chk("rsp_flags", rsp_flags, mon_e.flags);
          chk("rsp_err", rsp_err, mon_e.err);
          chk("alu_opcode", alu_opcode, mon_e.aop);
          chk("alu_x", alu_x, mon_e.ax);
          chk("alu_y", alu_y, mon_e.ay);
          chk("cpsr", cpsr, mon_e.cpsr);
        end
      end
    end
    prev_v = rsp_valid;
  end

  task automatic issue(input logic id, input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] r, input logic [4:0] fl, input logic err);
    logic got;
    @(posedge clk); #1;
    if (id == 1'b0) begin
      req0_opcode = op; req0_x = x; req0_y = y; req0_valid = 1'b1;
    end else begin
      req1_opcode = op; req1_x = x; req1_y = y; req1_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", {31'd0, got}, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      push(id, op, x, y, r, fl, err);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic rst_chk(input string p, input logic v, input logic rd0, input logic rd1, input logic bz,
                         input logic [15:0] r, input logic [4:0] f, input logic e, input logic id,
                         input logic [4:0] aop, input logic [15:0] ax, input logic [15:0] ay, input logic [3:0] cp);
    chk({p, "_rsp_valid"}, v, 0);
    chk({p, "_req0_ready"}, rd0, 0);
    chk({p, "_req1_ready"}, rd1, 0);
    chk({p, "_busy"}, bz, 0);
    chk({p, "_rsp_r"}, r, 0);
    chk({p, "_rsp_flags"}, f, 0);
    chk({p, "_rsp_err"}, e, 0);
    chk({p, "_rsp_id"}, id, 0);
    chk({p, "_alu_opcode"}, aop, 0);
    chk({p, "_alu_x"}, ax, 0);
    chk({p, "_alu_y"}, ay, 0);
    chk({p, "_cpsr"}, cp, 0);
  endtask

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    logic [4:0]  flags;
    logic        err;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic got;
    logic seen;
    int   lat;

    // id, opcode, x, y, expected r, expected {div,ov,neg,zero,cout}, expected err
    vt[0]  = '{1'b0, 5'b00001, 16'h7FFF, 16'h0001, 16'h8000, 5'b01100, 1'b0};
    vt[1]  = '{1'b1, 5'b00001, 16'hFFFF, 16'h0001, 16'h0000, 5'b00011, 1'b0};
    vt[2]  = '{1'b0, 5'b00010, 16'h0003, 16'h0005, 16'hFFFE, 5'b00100, 1'b0};
    vt[3]  = '{1'b1, 5'b10001, 16'h1111, 16'h2222, 16'h0000, 5'b00000, 1'b1};
    vt[4]  = '{1'b1, 5'b00101, 16'h0005, 16'h0005, 16'h0000, 5'b00011, 1'b0};
    vt[5]  = '{1'b0, 5'b01101, 16'h0010, 16'h0000, 16'h0000, 5'b10010, 1'b0};
    vt[6]  = '{1'b0, 5'b11101, 16'h0001, 16'h0001, 16'h0000, 5'b00000, 1'b1};
    vt[7]  = '{1'b0, 5'b01101, 16'h0010, 16'h0004, 16'h0004, 5'b00000, 1'b0};
    vt[8]  = '{1'b1, 5'b11110, 16'h0001, 16'h0002, 16'h0000, 5'b00100, 1'b0};
    vt[9]  = '{1'b1, 5'b11111, 16'hAAAA, 16'h5555, 16'h0000, 5'b00000, 1'b1};
    vt[10] = '{1'b1, 5'b11100, 16'h00FF, 16'h0F0F, 16'h0FF0, 5'b00000, 1'b0};
    vt[11] = '{1'b0, 5'b10000, 16'h1234, 16'h1234, 16'h0000, 5'b00010, 1'b0};
    vt[12] = '{1'b0, 5'b10111, 16'h0000, 16'h0000, 16'h0000, 5'b00000, 1'b1};
    vt[13] = '{1'b1, 5'b11000, 16'h8000, 16'h0001, 16'h8001, 5'b00100, 1'b0};

    // Reset with requests pending: ready must stay low.
    reset_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; s4_req0_valid = 1'b1; s4_req1_valid = 1'b0;
    req0_opcode = 5'b00001; req1_opcode = 5'b00001;
    req0_x = 16'h0; req0_y = 16'h0; req1_x = 16'h0; req1_y = 16'h0;
    rsp_ready = 1'b1; s4_rsp_ready = 1'b1;
    model_reset();
    #22;
    rst_chk("rst", rsp_valid, req0_ready, req1_ready, busy, rsp_r, rsp_flags, rsp_err, rsp_id,
            alu_opcode, alu_x, alu_y, cpsr);
    rst_chk("s4_rst", s4_rsp_valid, s4_req0_ready, s4_req1_ready, s4_busy, s4_rsp_r, s4_rsp_flags,
            s4_rsp_err, s4_rsp_id, s4_alu_opcode, s4_alu_x, s4_alu_y, s4_cpsr);
    req0_valid = 1'b0; req1_valid = 1'b0; s4_req0_valid = 1'b0;
    @(negedge clk); #1 reset_n = 1'b1;

    // Contention straight out of reset: grants alternate 0,1,0,1.
    @(posedge clk); #1;
    req0_opcode = 5'b00001; req0_x = 16'h0001; req0_y = 16'h0002;
    req1_opcode = 5'b11100; req1_x = 16'h00F0; req1_y = 16'h000F;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) got = 1'b1;
      end
      if (!got) begin
        chk("contend_timeout", {31'd0, got}, 32'd1);
        break;
      end
      chk("contend_grant", {req0_ready, req1_ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      if (k % 2 == 0) push(1'b0, 5'b00001, 16'h0001, 16'h0002, 16'h0003, 5'b00000, 1'b0);
      else            push(1'b1, 5'b11100, 16'h00F0, 16'h000F, 16'h00FF, 5'b00000, 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Table vectors, one requester at a time.
    for (int i = 0; i < 14; i++)
      issue(vt[i].id, vt[i].op, vt[i].x, vt[i].y, vt[i].r, vt[i].flags, vt[i].err);
    drain();

    // Back-pressure: response held for 5 cycles with both requesters waiting.
    @(posedge clk); #1 rsp_ready = 1'b0;
    issue(1'b0, 5'b00001, 16'h0001, 16'h0002, 16'h0003, 5'b00000, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("stall_rsp_seen", {31'd0, got}, 32'd1);
    req0_opcode = 5'b10001; req1_opcode = 5'b10001;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_r", rsp_r, 16'h0003);
      chk("stall_rsp_flags", rsp_flags, 0);
      chk("stall_rsp_id", rsp_id, 0);
      chk("stall_rsp_err", rsp_err, 0);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    drain();

    // SETTLE=4 instance: reset in WAIT discards the operation.
    @(posedge clk); #1;
    req0_opcode = 5'b00001; req0_x = 16'h0001; req0_y = 16'h0002; s4_req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s4_req0_ready) got = 1'b1;
    end
    chk("s4_accept", {31'd0, got}, 32'd1);
    @(posedge clk); #1 s4_req0_valid = 1'b0;
    @(posedge clk); #1;
    chk("s4_busy_wait", s4_busy, 1);
    chk("s4_no_rsp_wait", s4_rsp_valid, 0);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    rst_chk("s4_midrst", s4_rsp_valid, s4_req0_ready, s4_req1_ready, s4_busy, s4_rsp_r, s4_rsp_flags,
            s4_rsp_err, s4_rsp_id, s4_alu_opcode, s4_alu_x, s4_alu_y, s4_cpsr);
    @(negedge clk); #1 reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s4_rsp_valid) seen = 1'b1;
    end
    chk("s4_discarded", {31'd0, seen}, 32'd0);

    // Next request after the reset is served with SETTLE latency.
    @(posedge clk); #1;
    req0_opcode = 5'b00001; req0_x = 16'h0005; req0_y = 16'h0006; s4_req0_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s4_req0_ready) got = 1'b1;
    end
    chk("s4_accept2", {31'd0, got}, 32'd1);
    @(posedge clk); #1 s4_req0_valid = 1'b0;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s4_rsp_valid) got = 1'b1;
      else lat++;
    end
    chk("s4_latency", lat, S4);
    chk("s4_rsp_r", s4_rsp_r, 16'h000B);
    chk("s4_rsp_flags", s4_rsp_flags, 0);
    chk("s4_rsp_id", s4_rsp_id, 0);
    chk("s4_rsp_err", s4_rsp_err, 0);
    chk("s4_alu_opcode", s4_alu_opcode, 5'b00001);

    // SETTLE=1 instance still works after the shared reset.
    issue(1'b1, 5'b00001, 16'h0002, 16'h0003, 16'h0005, 5'b00000, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width of the shared ALU.
REQ-002 Parameter SETTLE, default 1, legal 1..7, cycles from ALU input drive to result capture.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 reqN_valid / reqN_ready  in/out  1  per requester N=0,1, valid/ready handshake.
REQ-006 reqN_opcode  in  5  ALU opcode from requester N.
REQ-007 reqN_x, reqN_y  in  WIDTH  operands from requester N.
REQ-008 rsp_valid / rsp_ready  out/in  1  response handshake.
REQ-009 rsp_id  out  1  index of the requester that owns the response.
REQ-010 rsp_r  out  WIDTH  captured ALU result.
REQ-011 rsp_flags  out  5  {div_invalid, overflow, negative, zero, cout} captured.
REQ-012 rsp_err  out  1  illegal opcode, not issued to the ALU.
REQ-013 alu_opcode  out  5 ; alu_x, alu_y  out  WIDTH  registered drive to the shared ALU.
REQ-014 alu_r  in  WIDTH ; alu_overflow, alu_negative, alu_zero, alu_cout, alu_div_invalid  in  1  ALU outputs.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 cpsr  out  4  {negative, zero, cout, overflow} of the last legal completed operation.

Function
REQ-017 FSM states IDLE, WAIT, RESP; only one operation in flight.
REQ-018 In IDLE, reqN_ready SHALL be high only for the granted requester; ready is low in WAIT and RESP.
REQ-019 Grant: one valid requester wins; both valid -> requester differing from last_grant wins; last_grant updates on acceptance.
REQ-020 Acceptance (valid&ready) latches opcode, x, y, id; legal opcode -> WAIT with counter loaded to SETTLE-1; illegal -> RESP.
REQ-021 Legal opcodes: 5'b00000..5'b10000, 5'b11000..5'b11100, 5'b11110; all others (10001..10111, 11101, 11111) are illegal.
REQ-022 alu_opcode/alu_x/alu_y SHALL update from the latched values on the acceptance edge of a legal op and hold until the next legal acceptance.
REQ-023 WAIT decrements the counter; at counter 0 the edge captures alu_r and flags into rsp_r/rsp_flags, clears rsp_err, enters RESP.
REQ-024 rsp_valid is high exactly in RESP; first rsp_valid cycle is SETTLE cycles after the acceptance edge.
REQ-025 Illegal opcode: rsp_r=0, rsp_flags=0, rsp_err=1, rsp_valid one cycle after acceptance; ALU drive and cpsr unchanged.
REQ-026 rsp_* SHALL hold stable while rsp_valid & !rsp_ready.
REQ-027 rsp_valid & rsp_ready -> IDLE; no acceptance in the same cycle; next acceptance earliest the following cycle.
REQ-028 Compare opcodes (00101, 11110) are captured as normal (rsp_r equals ALU's 0).

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, counter 0, last_grant=1 (req0 wins first contention).
REQ-030 Reset values: rsp_valid=0, rsp_r=0, rsp_flags=0, rsp_err=0, rsp_id=0, alu_opcode=0, alu_x=0, alu_y=0, cpsr=0, busy=0, reqN_ready=0 while reset_n low.
REQ-031 Reset mid-operation SHALL discard the in-flight op with no response.

Configuration
REQ-032 Macro ALU_ARBITER_CPSR_EN defined: cpsr register updates at each legal capture edge from alu_negative/zero/cout/overflow.
REQ-033 Macro ALU_ARBITER_CPSR_EN undefined: no cpsr register; cpsr tied to 4'b0000; all other behaviour identical.

Verification
REQ-034 req0 ADD 00001 x=16'h7FFF y=16'h0001, SETTLE=1 -> rsp_valid one cycle after accept, rsp_r=16'h8000, overflow=1, negative=1, rsp_id=0.
REQ-035 req0 and req1 valid together after reset, repeated -> grants 0,1,0,1 in order; each rsp_id matches.
REQ-036 rsp_ready low 5 cycles -> rsp_* stable, both reqN_ready low, busy=1 throughout.
REQ-037 req1 opcode 5'b10001 -> rsp_err=1, rsp_r=0, rsp_flags=0 one cycle after accept; alu_opcode and cpsr unchanged.
REQ-038 DIV 01101 x=16'h0010 y=16'h0000 -> rsp_flags[4]=1; with ALU_ARBITER_CPSR_EN, cpsr reflects ALU flags.
REQ-039 reset_n pulsed low in WAIT with SETTLE=4 -> no rsp_valid, all outputs at reset values, next request served normally.
